// File: rtl/mem_arb_pkg.sv
// mem_arbiter shared types: FSM states, owner IDs, default widths.
// Used by mem_arbiter and mem_arb_pick.
package mem_arb_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_LINE_W = 256;

  // one-hot grant bit positions
  localparam int GNT_IC = 0;
  localparam int GNT_DC = 1;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RESP
  } state_e;

  typedef enum logic {
    OWN_IC,
    OWN_DC
  } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way request picker producing a one-hot grant.
// MEM_ARB_RR_EN: ties go to the requester that is not last_owner_i.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       ic_req_i,
  input  logic       dc_req_i,
`ifdef MEM_ARB_RR_EN
  input  logic       last_owner_i,
`endif
  output logic [1:0] gnt_o
);

  // pick a winner; ties resolved by round-robin or fixed D-cache priority
  always_comb begin
    gnt_o = '0;
    unique case (1'b1)
      (ic_req_i && dc_req_i): begin
`ifdef MEM_ARB_RR_EN
        if (last_owner_i == logic'(OWN_DC)) gnt_o[GNT_IC] = 1'b1;
        else                                gnt_o[GNT_DC] = 1'b1;
`else
        gnt_o[GNT_DC] = 1'b1;
`endif
      end
      (dc_req_i && !ic_req_i): gnt_o[GNT_DC] = 1'b1;
      (ic_req_i && !dc_req_i): gnt_o[GNT_IC] = 1'b1;
      default:                 gnt_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises I-cache and D-cache line transactions onto one memory port.
// MEM_ARB_RR_EN selects round-robin tie breaking (else D-cache priority).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = MEM_ADDR_W,
  parameter int LINE_W      = MEM_LINE_W,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ic_req_i,
  input  logic              ic_write_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  input  logic [LINE_W-1:0] ic_data_i,
  output logic              ic_ack_o,
  output logic [LINE_W-1:0] ic_data_o,
  input  logic              dc_req_i,
  input  logic              dc_write_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic [LINE_W-1:0] dc_data_i,
  output logic              dc_ack_o,
  output logic [LINE_W-1:0] dc_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [LINE_W-1:0] mem_data_i,
  output logic              err_o
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC);

  state_e            state_q;
  owner_e            owner_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              en_q;
  logic              ic_ack_q;
  logic              dc_ack_q;
  logic [LINE_W-1:0] ic_data_q;
  logic [LINE_W-1:0] dc_data_q;
  logic [WD_W-1:0]   wd_q;
  logic [WD_W-1:0]   wd_d;
  logic              err_q;
  logic [1:0]        gnt;

`ifdef MEM_ARB_RR_EN
  owner_e last_owner_q;

  // remember who was served last, updated as the response retires
  always_ff @(posedge clk_i) begin
    if (rst_i)                last_owner_q <= OWN_IC;
    else if (state_q == RESP) last_owner_q <= owner_q;
  end
`endif

  mem_arb_pick u_pick (
    .ic_req_i     (ic_req_i),
    .dc_req_i     (dc_req_i),
`ifdef MEM_ARB_RR_EN
    .last_owner_i (last_owner_q == OWN_DC),
`endif
    .gnt_o        (gnt)
  );

  // main FSM: latch winner, hold memory port, return one-cycle ack
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      owner_q   <= OWN_IC;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      en_q      <= 1'b0;
      ic_ack_q  <= 1'b0;
      dc_ack_q  <= 1'b0;
      ic_data_q <= '0;
      dc_data_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (gnt[GNT_DC]) begin
            state_q <= GRANT;
            en_q    <= 1'b1;
            owner_q <= OWN_DC;
            wr_q    <= dc_write_i;
            addr_q  <= dc_addr_i;
            wdata_q <= dc_data_i;
          end else if (gnt[GNT_IC]) begin
            state_q <= GRANT;
            en_q    <= 1'b1;
            owner_q <= OWN_IC;
            wr_q    <= ic_write_i;
            addr_q  <= ic_addr_i;
            wdata_q <= ic_data_i;
          end
        end
        GRANT: begin
          if (mem_ack_i) begin
            state_q <= RESP;
            en_q    <= 1'b0;
            if (owner_q == OWN_DC) begin
              dc_ack_q  <= 1'b1;
              dc_data_q <= wr_q ? '0 : mem_data_i;
            end else begin
              ic_ack_q  <= 1'b1;
              ic_data_q <= wr_q ? '0 : mem_data_i;
            end
          end
        end
        RESP: begin
          state_q   <= IDLE;
          ic_ack_q  <= 1'b0;
          dc_ack_q  <= 1'b0;
          ic_data_q <= '0;
          dc_data_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // watchdog next count: clear on grant, count GRANT cycles, saturate
  always_comb begin
    wd_d = wd_q;
    if (state_q == IDLE && gnt != 2'b00)
      wd_d = '0;
    else if (state_q == GRANT && wd_q < WD_MAX)
      wd_d = wd_q + WD_W'(1);
  end

  // watchdog count and sticky timeout flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      if (wd_d == WD_MAX) err_q <= 1'b1;
    end
  end

  assign mem_enable_o = en_q;
  assign mem_write_o  = wr_q;
  assign mem_addr_o   = addr_q;
  assign mem_data_o   = wdata_q;
  assign ic_ack_o     = ic_ack_q;
  assign ic_data_o    = ic_data_q;
  assign dc_ack_o     = dc_ack_q;
  assign dc_data_o    = dc_data_q;
  assign err_o        = err_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single 256-bit Data_Memory port between the instruction-cache refill path and the data cache. It sits between both caches and Data_Memory, and serialises their line transactions. It latches each winning request and holds it on the memory port until `mem_ack_i`, then returns a registered one-cycle ack with the read line to the owner. A sticky watchdog flags a memory that never acknowledges.

## Interface
Parameters:
- `ADDR_W`, 32: byte address width.
- `LINE_W`, 256: cache line / memory word width.
- `TIMEOUT_CYC`, 64: number of granted cycles without `mem_ack_i` before `err_o` sets; must be at least 2.

Ports (suffix `_i` = input, `_o` = output; one clock; reset is synchronous and active-high):
- `clk_i` in 1: clock; all state changes on the rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `ic_req_i` in 1: I-cache requests memory; held high until `ic_ack_o`.
- `ic_write_i` in 1: 1 = write line, 0 = read line.
- `ic_addr_i` in `ADDR_W`: line address.
- `ic_data_i` in `LINE_W`: write line.
- `ic_ack_o` out 1: one-cycle completion pulse.
- `ic_data_o` out `LINE_W`: read line; valid while `ic_ack_o` is high.
- `dc_req_i`, `dc_write_i`, `dc_addr_i`, `dc_data_i`, `dc_ack_o`, `dc_data_o`: same definitions for the D-cache.
- `mem_enable_o` out 1: memory request; held high for the whole transaction.
- `mem_write_o` out 1: memory write.
- `mem_addr_o` out `ADDR_W`: memory address.
- `mem_data_o` out `LINE_W`: memory write data.
- `mem_ack_i` in 1: one-cycle done pulse from memory.
- `mem_data_i` in `LINE_W`: memory read line; valid with `mem_ack_i`.
- `err_o` out 1: sticky timeout flag.

## Operation
FSM states:
- IDLE
  - No request: stay in IDLE.
  - One request: latch that requester's write/addr/data and its owner ID, go to GRANT.
  - Both request: pick the winner per Configuration.
- GRANT
  - Drive the latched write/addr/data onto the memory port with `mem_enable_o`=1.
  - On `mem_ack_i`: latch `mem_data_i` into the response register and go to RESP.
- RESP
  - Pulse the owner's ack for one cycle, with `*_data_o` = latched line. For writes, the latched line is don't-care and driven as 0.
  - Update `last_owner`; go to IDLE.
  - Requests are not sampled in this state.

Other rules:
- The non-owner's ack and data stay 0.
- Requester inputs that change after grant are ignored; the latched copy is used.
- Watchdog:
  - The counter clears on entry to GRANT and counts each GRANT cycle, saturating at `TIMEOUT_CYC`.
  - On reaching `TIMEOUT_CYC`, `err_o` sets and stays set until `rst_i`.
  - The transaction is not aborted; the arbiter keeps waiting for `mem_ack_i`.
- A `mem_ack_i` outside GRANT is ignored.
- A requester that drops its request while in GRANT still receives its ack; dropping a request is not allowed.

## Timing
- Reset:
  - FSM returns to IDLE; all outputs are 0, including `err_o`.
  - `last_owner` = IC, so the D-cache wins the first tie.
  - The latched request and the response register clear.
  - Reset mid-GRANT abandons the transaction with no ack. Data_Memory resets on the same `rst_i`.
- Request sampled at edge N → GRANT from N, with `mem_enable_o` and address registered-valid in cycle N+1.
- `mem_ack_i` sampled at edge M → owner ack high for exactly cycle M+1 (RESP), IDLE at M+2.
- The earliest new grant is sampled at edge M+2. `mem_enable_o` is therefore low for at least 2 cycles between transactions, which Data_Memory requires to restart its latency counter.
- A requester seeing its ack at edge M+1 must drop its request before edge M+2, or it is re-granted.
- A request asserted during RESP is served at the next IDLE arbitration.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin on ties. The winner is the requester that is not `last_owner`.
- `MEM_ARB_RR_EN` undefined:
  - Fixed priority: the D-cache always wins ties.
  - `last_owner` is not implemented.
  - The I-cache may starve only if the D-cache re-requests back to back.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum (IDLE, GRANT, RESP);
  - the owner enum (OWN_IC, OWN_DC);
  - default `LINE_W`/`ADDR_W` constants.
- One sub-module, `mem_arb_pick`: combinational 2-way pick taking both requests and `last_owner`, producing a one-hot grant.
  - Round-robin or fixed priority is selected inside it under `MEM_ARB_RR_EN`.
- The watchdog counter and the FSM stay in `mem_arbiter`.

## Test plan
- Single D-cache read of addr 0x0040, with memory acking 10 cycles after enable:
  - `mem_addr_o`=0x0040 and `mem_write_o`=0.
  - `dc_ack_o` pulses one cycle with `dc_data_o` = `ECFA` repeated.
  - `ic_ack_o` stays 0.
- IC and DC request at the same edge, each read; rerun with both requesting again:
  - Both builds: DC is served first.
  - Second round with `MEM_ARB_RR_EN`: IC wins.
  - Second round without it: DC wins again.
- DC write of line `0x0123…3210` to 0x0200 while IC holds a read to 0x0000:
  - The write completes first, and `mem_data_o` equals the latched line even though `dc_data_i` is changed mid-GRANT.
  - IC then gets `0000_1111…FFFF`.
- Memory never acks, `TIMEOUT_CYC`=64:
  - `err_o` rises after 64 GRANT cycles.
  - A late ack at cycle 100 still produces the owner ack, and `err_o` stays 1.
- `rst_i` asserted 5 cycles into GRANT:
  - The next cycle shows all outputs 0, no ack, and the FSM in IDLE.
  - A new request is then served normally.
- Back-to-back requests: check the ack-to-next-enable gap is ≥2 cycles and that a request asserted during RESP is granted at the following edge.
